// File: rtl/mem_write_seq_if.sv
// Write-sequencer handshake and bus bundle.
// The decoder side drives start/kind/wait_n; the sequencer drives the rest.
interface mem_write_seq_if #(
  parameter int SEL_WIDTH = 6
);
  logic                 start;
  logic [2:0]           kind;
  logic                 wait_n;
  logic [SEL_WIDTH-1:0] data_select;
  logic                 mem_req;
  logic                 mem_wr;
  logic                 addr_inc;
  logic                 addr_dec;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, kind, wait_n,
    input  data_select, mem_req, mem_wr,
    input  addr_inc, addr_dec, busy, done, err
  );

  modport slave (
    input  start, kind, wait_n,
    output data_select, mem_req, mem_wr,
    output addr_inc, addr_dec, busy, done, err
  );
endinterface

// File: rtl/mem_write_seq.sv
// Z80 memory write bus-cycle sequencer.
// Drives data-out mux select, request/write strobes and address steps.
module mem_write_seq #(
  parameter int SEL_WIDTH      = 6,
  parameter int MAX_WAIT       = 255,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  mem_write_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, T1, T2, T3, STEP, FIN
  } state_e;

  localparam logic [2:0] K_BREG = 3'd0;
  localparam logic [2:0] K_BDIN = 3'd1;
  localparam logic [2:0] K_WLE  = 3'd2;
  localparam logic [2:0] K_PUSH = 3'd3;
  localparam logic [2:0] K_CALL = 3'd4;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST =
    WAIT_CNT_WIDTH'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  state_e                    state;
  logic [2:0]                kind_q;
  logic                      idx;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic                      timeout;
  logic                      two_byte;

  function automatic logic [SEL_WIDTH-1:0] sel_of(
    input logic [2:0] k,
    input logic       second
  );
    logic [SEL_WIDTH-1:0] s;
    s = '0;
    unique case (k)
      K_BREG:  s[4] = 1'b1;
      K_BDIN:  s[1] = 1'b1;
      K_WLE:   s[0] = second;
      K_PUSH:  s[0] = ~second;
      K_CALL: begin
        s[3] = ~second;
        s[2] = second;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // Abort on the wait cycle that brings the count to MAX_WAIT.
  assign timeout  = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
  assign two_byte = (kind_q >= K_WLE) && !idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      kind_q          <= '0;
      idx             <= 1'b0;
      wait_cnt        <= '0;
      bus.data_select <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.addr_inc    <= 1'b0;
      bus.addr_dec    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.addr_inc <= 1'b0;
      bus.addr_dec <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.kind <= K_CALL) begin
              state           <= T1;
              kind_q          <= bus.kind;
              idx             <= 1'b0;
              wait_cnt        <= '0;
              bus.data_select <= sel_of(bus.kind, 1'b0);
              bus.mem_req     <= 1'b1;
              bus.busy        <= 1'b1;
            end else begin
              state    <= FIN;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end
          end
        end
        T1: begin
          state      <= T2;
          bus.mem_wr <= 1'b1;
        end
        T2: begin
          if (bus.wait_n) begin
            state      <= T3;
            bus.mem_wr <= 1'b0;
          end else if (timeout) begin
            state           <= FIN;
            bus.mem_wr      <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.data_select <= '0;
            bus.done        <= 1'b1;
            bus.err         <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        T3: begin
          bus.mem_req     <= 1'b0;
          bus.data_select <= '0;
          if (two_byte) begin
            state        <= STEP;
            bus.addr_inc <= (kind_q == K_WLE);
            bus.addr_dec <= (kind_q != K_WLE);
          end else begin
            state    <= FIN;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        STEP: begin
          state           <= T1;
          idx             <= 1'b1;
          wait_cnt        <= '0;
          bus.data_select <= sel_of(kind_q, 1'b1);
          bus.mem_req     <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_seq.sv
// Bench for mem_write_seq: directed and random write sequences
// checked cycle by cycle against a per-kind byte-plan model.
module tb_mem_write_seq;

  localparam int SW = 6;
  localparam int MW = 4;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          req;
    logic          wr;
    logic          inc;
    logic          dec;
    logic          busy;
    logic          done;
    logic          err;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  obs_t obs;
  int   n_chk  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  logic wn_q[$];

  mem_write_seq_if #(.SEL_WIDTH(SW)) bus ();

  mem_write_seq #(
    .SEL_WIDTH(SW),
    .MAX_WAIT(MW),
    .WAIT_CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.data_select, bus.mem_req, bus.mem_wr,
                bus.addr_inc, bus.addr_dec, bus.busy,
                bus.done, bus.err};

  task automatic check(input string tag, input obs_t e);
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  function automatic logic [SW-1:0] onehot(input int b);
    logic [SW-1:0] s;
    s = '0;
    if (b >= 0) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(
    input logic [SW-1:0] s,
    input logic req, input logic wr,
    input logic inc, input logic dec,
    input logic busy, input logic done,
    input logic err, input logic wn
  );
    exp_q.push_back({s, req, wr, inc, dec, busy, done, err});
    wn_q.push_back(wn);
  endfunction

  // Expected per-cycle outputs and wait_n to drive, from the byte plan.
  task automatic plan(input int k, input int w0, input int w1);
    int            bits[$];
    int            dir;
    int            w;
    logic [SW-1:0] s;
    exp_q.delete();
    wn_q.delete();
    dir = 0;
    case (k)
      0: bits = '{4};
      1: bits = '{1};
      2: begin bits = '{-1, 0}; dir = 1;  end
      3: begin bits = '{0, -1}; dir = -1; end
      4: begin bits = '{3, 2};  dir = -1; end
      default: begin
        push('0, 0, 0, 0, 0, 0, 1, 1, rnd());
        return;
      end
    endcase
    for (int b = 0; b < bits.size(); b++) begin
      w = (b == 0) ? w0 : w1;
      s = onehot(bits[b]);
      push(s, 1, 0, 0, 0, 1, 0, 0, rnd());
      if (w >= MW) begin
        repeat (MW) push(s, 1, 1, 0, 0, 1, 0, 0, 1'b0);
        push('0, 0, 0, 0, 0, 0, 1, 1, rnd());
        return;
      end
      repeat (w) push(s, 1, 1, 0, 0, 1, 0, 0, 1'b0);
      push(s, 1, 1, 0, 0, 1, 0, 0, 1'b1);
      push(s, 1, 0, 0, 0, 1, 0, 0, rnd());
      if (b + 1 < bits.size())
        push('0, 0, 0, dir > 0, dir < 0, 1, 0, 0, rnd());
    end
    push('0, 0, 0, 0, 0, 0, 1, 0, rnd());
  endtask

  task automatic run(input string tag, input int k,
                     input int w0, input int w1, input bit noise);
    plan(k, w0, w1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.kind  = 3'(k);
    @(posedge clk);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.start  = noise ? rnd() : 1'b0;
      bus.kind   = 3'($urandom_range(0, 7));
      bus.wait_n = wn_q[i];
      @(negedge clk);
      check($sformatf("%s c%0d", tag, i + 1), exp_q[i]);
      @(posedge clk);
      #1;
    end
    bus.start  = 1'b0;
    bus.wait_n = 1'b1;
    @(negedge clk);
    check($sformatf("%s idle", tag), '0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.kind   = 3'd0;
    bus.wait_n = 1'b1;
    @(negedge clk);
    check("reset", '0);
    reset = 1'b0;

    run("byte_reg", 0, 0, 0, 1'b0);
    run("word_le", 2, 0, 0, 1'b0);
    run("call_pc_w3", 4, 3, 0, 1'b0);
    run("byte_din_to", 1, 9, 0, 1'b0);
    run("illegal6", 6, 0, 0, 1'b1);
    run("push_w1", 3, 1, 2, 1'b1);
    run("call_to2", 4, 0, 5, 1'b1);
    run("byte_reg_n", 0, 2, 0, 1'b1);

    // Asynchronous reset in T2 of a PUSH.
    @(negedge clk);
    bus.start = 1'b1;
    bus.kind  = 3'd3;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.wait_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pre", {onehot(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", '0);
    @(negedge clk);
    reset      = 1'b0;
    bus.wait_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_idle%0d", i), '0);
    end

    for (int t = 0; t < 30; t++) begin
      run($sformatf("rnd%0d", t), $urandom_range(0, 7),
          $urandom_range(0, 5), $urandom_range(0, 5), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_seq.md
Name: mem_write_seq

Overview:
Sequences CPU memory write bus cycles for the Z80 core. It drives the one-hot select of the memory data-out byte mux and the request, write, wait and address-step signals for one- and two-byte writes: register stores, immediate stores, 16-bit stores, PUSH and CALL return-address pushes. It sits between the instruction decoder, the memory data-out mux and the address unit.

Parameters:
SEL_WIDTH, 6, width of data_select; must match the memory data-out mux select width.
MAX_WAIT, 255, maximum consecutive wait cycles tolerated in T2 before abort; 0 disables the timeout.
WAIT_CNT_WIDTH, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a write sequence; sampled only in IDLE.
kind  input  3  sequence type, sampled with start: 0 BYTE_REG, 1 BYTE_DIN, 2 WORD_LE, 3 WORD_PUSH, 4 CALL_PC; 5-7 illegal.
wait_n  input  1  memory wait, active low; sampled at the end of T2.
data_select  output  SEL_WIDTH  one-hot mux select; all zero selects reg_mem_dout[7:0].
mem_req  output  1  memory request, active high.
mem_wr  output  1  write strobe, active high.
addr_inc  output  1  one-cycle pulse: address unit +1.
addr_dec  output  1  one-cycle pulse: address unit -1.
busy  output  1  high from T1 of the first byte through T3 of the last byte.
done  output  1  one-cycle completion pulse.
err  output  1  one-cycle pulse with done on illegal kind or wait timeout.

Behaviour:
- Reset is asynchronous: state goes to IDLE immediately and every output is 0 (data_select = 0). Reset mid-sequence aborts that write with no completion pulse.
- States: IDLE, T1, T2, T3, STEP, FIN. Outputs decode from registered state plus the latched kind and byte index.
- Select bits: bit0 dout_hi, bit1 din_lo, bit2 pc_lo, bit3 pc_hi, bit4 regfile 8-bit, bit5 regfile 16-bit lo. All-zero selects dout_lo.
- Byte order per kind; second byte and step direction given where present:
  - BYTE_REG: bit4.
  - BYTE_DIN: bit1.
  - WORD_LE: 0, then bit0; address step inc.
  - WORD_PUSH: bit0, then 0; address step dec.
  - CALL_PC: bit3, then bit2; address step dec.
- IDLE: all outputs 0.
  - start=1 with a legal kind: latch kind, byte index = 0, go to T1.
  - start=1 with an illegal kind: go to FIN with err set; no bus activity.
- T1: mem_req=1, mem_wr=0, data_select = current byte's select. Next state T2.
- T2: mem_req=1, mem_wr=1.
  - wait_n=1: go to T3.
  - wait_n=0: stay in T2 and increment the wait counter.
  - When the counter reaches MAX_WAIT (MAX_WAIT≠0) with wait_n still 0: go to FIN with err set. mem_wr drops on the next cycle and the second byte is skipped.
  - The wait counter clears on entry to T1.
- T3: mem_req=1, mem_wr=0, data_select held.
  - Second byte pending: go to STEP.
  - Otherwise: go to FIN.
- STEP: mem_req=0, mem_wr=0, data_select=0, busy=1. Pulse addr_inc or addr_dec for exactly one cycle. Byte index = 1. Next state T1.
- FIN: done=1, err as latched, busy=0, data_select=0. Next state IDLE. start is ignored in FIN.
- data_select is stable and one-hot (or zero) through T1-T3 of each byte. It never changes while mem_wr=1.
- start while busy, or while in FIN, is ignored and not queued.
- Latency from the start edge to the done pulse:
  - single-byte write: 4 cycles (T1, T2, T3, FIN);
  - two-byte write: 8 cycles;
  - each wait cycle adds 1.
- addr_inc and addr_dec are never both high. No address step occurs for single-byte kinds or after an abort.

Test Plan:
- Reset during T2 of WORD_PUSH -> mem_wr, mem_req and data_select go to 0 within the reset cycle; IDLE after release; no done pulse.
- BYTE_REG, wait_n=1 -> T1-T3 each show data_select=6'b010000; mem_wr high only in cycle 2; done in cycle 4; no addr pulses; err=0.
- WORD_LE, wait_n=1 -> byte 0 uses select 0, then one addr_inc pulse in the STEP cycle, then byte 1 uses 6'b000001; done in cycle 8.
- CALL_PC with wait_n=0 for 3 cycles during the first T2 -> T2 lasts 4 cycles; selects are 6'b001000 then 6'b000100; one addr_dec pulse; done in cycle 11.
- MAX_WAIT=4, BYTE_DIN, wait_n held 0 -> err and done pulse together after 4 wait cycles; mem_wr low afterwards; no second byte or addr pulse.
- kind=6 -> done and err together 1 cycle after start, no mem_req; a start asserted during busy or FIN is ignored and produces no second sequence.
